// File: rtl/alu16_seq.sv
// Command sequencer for the 16-bit ALU: one command at a time over valid/ready,
// optional flag-conditioned execution and cnt+1 repeated iterations with the
// destination fed back as the S operand after the first pass.
module alu16_seq #(
  parameter int unsigned AW = 3,
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_srcR,
  input  logic [AW-1:0] cmd_srcS,
  input  logic [CW-1:0] cmd_cnt,
  input  logic [1:0]    cmd_cond,
  output logic [AW-1:0] R_Addr,
  output logic [AW-1:0] S_Addr,
  output logic [AW-1:0] W_Addr,
  output logic          W_En,
  output logic [3:0]    Alu_Op,
  input  logic          N,
  input  logic          Z,
  input  logic          C,
  output logic          N_q,
  output logic          Z_q,
  output logic          C_q,
  output logic          busy,
  output logic          done
);

  localparam int unsigned OPW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] srcr_q, srcr_d;
  logic [AW-1:0] srcs_q, srcs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] iter_q, iter_d;
  logic          n_d, z_d, c_d;
  logic          cond_ok;

  // Next-cycle values of the registered outputs
  logic           ready_d, busy_d, done_d, wen_d;
  logic [OPW-1:0] alu_op_d;
  logic [AW-1:0]  r_addr_d, s_addr_d, w_addr_d;

  // Condition check against the stored flags at the handshake edge
  always_comb begin
    cond_ok = 1'b1;
    case (cmd_cond)
      2'b00:   cond_ok = 1'b1;
      2'b01:   cond_ok = Z_q;
      2'b10:   cond_ok = N_q;
      default: cond_ok = C_q;
    endcase
  end

  // Next-state, command capture, flag update and output decode
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dst_d    = dst_q;
    srcr_d   = srcr_q;
    srcs_d   = srcs_q;
    cnt_d    = cnt_q;
    iter_d   = iter_q;
    n_d      = N_q;
    z_d      = Z_q;
    c_d      = C_q;
    ready_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    wen_d    = 1'b0;
    alu_op_d = '0;
    r_addr_d = '0;
    s_addr_d = '0;
    w_addr_d = '0;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d    = cmd_op;
          dst_d   = cmd_dst;
          srcr_d  = cmd_srcR;
          srcs_d  = cmd_srcS;
          cnt_d   = cmd_cnt;
          iter_d  = '0;
          state_d = cond_ok ? EXEC : DONE;
        end
      end
      EXEC: begin
        n_d = N;
        z_d = Z;
        c_d = C;
        // Compare before increment so cnt at its maximum never wraps early
        if (iter_q == cnt_q) begin
          state_d = DONE;
        end else begin
          iter_d = iter_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs follow the state being entered so they are valid for that cycle
    case (state_d)
      IDLE: begin
        ready_d = 1'b1;
      end
      EXEC: begin
        busy_d   = 1'b1;
        wen_d    = 1'b1;
        alu_op_d = op_d;
        r_addr_d = srcr_d;
        w_addr_d = dst_d;
        s_addr_d = (iter_d == '0) ? srcs_d : dst_d;
      end
      DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        ready_d = 1'b0;
      end
    endcase
  end

  // State, command and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      dst_q     <= '0;
      srcr_q    <= '0;
      srcs_q    <= '0;
      cnt_q     <= '0;
      iter_q    <= '0;
      N_q       <= 1'b0;
      Z_q       <= 1'b0;
      C_q       <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      W_En      <= 1'b0;
      Alu_Op    <= '0;
      R_Addr    <= '0;
      S_Addr    <= '0;
      W_Addr    <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dst_q     <= dst_d;
      srcr_q    <= srcr_d;
      srcs_q    <= srcs_d;
      cnt_q     <= cnt_d;
      iter_q    <= iter_d;
      N_q       <= n_d;
      Z_q       <= z_d;
      C_q       <= c_d;
      cmd_ready <= ready_d;
      busy      <= busy_d;
      done      <= done_d;
      W_En      <= wen_d;
      Alu_Op    <= alu_op_d;
      R_Addr    <= r_addr_d;
      S_Addr    <= s_addr_d;
      W_Addr    <= w_addr_d;
    end
  end

endmodule

// File: doc/alu16_seq.md
Name: alu16_seq

Overview:
Command sequencer that drives the 16-bit ALU's operand-select and op-code inputs, and consumes its N/Z/C status outputs. Accepts one command at a time over a valid/ready handshake. Issues register-file read/write addresses and the 4-bit ALU op, and latches ALU flags into a status register. Supports conditional execution on stored flags and repeated execution, e.g. shift-by-n or add-n-times, using the destination as the S operand.

Parameters:
AW, 3, register-file address width (8 registers)
CW, 4, repeat-count width

Ports:
clk  in  1  system clock, all state updates on rising edge
reset_n  in  1  synchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept command
cmd_op  in  4  ALU op code, passed unchanged to Alu_Op
cmd_dst  in  AW  destination register
cmd_srcR  in  AW  R operand register
cmd_srcS  in  AW  S operand register for first iteration
cmd_cnt  in  CW  extra iterations; op executes cmd_cnt+1 times
cmd_cond  in  2  00 always, 01 if Z_q, 10 if N_q, 11 if C_q
R_Addr  out  AW  register-file read port A (to ALU R)
S_Addr  out  AW  register-file read port B (to ALU S)
W_Addr  out  AW  register-file write address
W_En  out  1  register-file write enable
Alu_Op  out  4  ALU operation select
N, Z, C  in  1 each  ALU combinational status
N_q, Z_q, C_q  out  1 each  latched status register
busy  out  1  command in progress
done  out  1  one-cycle pulse at command completion

Behaviour:
- Reset (reset_n=0 at edge) puts the block in state IDLE.
- Reset values: cmd_ready=1, busy=0, done=0, W_En=0, Alu_Op=0000, R_Addr=S_Addr=W_Addr=0, N_q=Z_q=C_q=0, iteration counter=0.
- Reset has priority over every other event, including mid-command.
- After reset mid-EXEC, W_En is 0 in the next cycle and no further writes occur.
- States: IDLE, EXEC, DONE.
- IDLE:
  - cmd_ready=1, busy=0.
  - Handshake when cmd_valid&cmd_ready at an edge: capture op/dst/srcR/srcS/cnt into registers, iter<=0.
  - Evaluate cmd_cond against the current N_q/Z_q/C_q at that edge.
  - Condition true -> EXEC. Condition false -> DONE, with no write and flags unchanged.
- EXEC:
  - cmd_ready=0, busy=1, W_En=1.
  - Alu_Op=op_q, R_Addr=srcR_q, W_Addr=dst_q.
  - S_Addr=srcS_q when iter==0, else dst_q.
  - At each edge: N_q/Z_q/C_q <= N/Z/C.
  - If iter==cnt_q -> DONE, else iter<=iter+1.
- DONE:
  - done=1, busy=1, cmd_ready=0, W_En=0, Alu_Op=0000.
  - Next edge -> IDLE.
- Outside EXEC: W_En=0, all addresses 0, Alu_Op=0000.
- Latency with handshake at edge 0:
  - EXEC occupies cycles 1..cnt+1; done is high in cycle cnt+2; next command can be accepted at the edge ending cycle cnt+3.
  - Skipped command: done high in cycle 1; ready again in cycle 2.
- One write per EXEC cycle. The register file writes at the edge, so the next iteration reads the updated dst. No bypass is needed.
- cmd_cnt at maximum (15) gives 16 iterations. The counter must not wrap before the compare.
- cmd_valid while busy is ignored; command fields are only sampled at the handshake.
- srcS==dst or srcR==dst is legal. Iteration 0 reads the old dst value.
- Flags reflect only the last executed iteration. Skipped commands never modify flags.

Test Plan:
1. reg1=0x0003, reg2=0x0005; cmd op=0100, srcR=1, srcS=2, dst=3, cnt=0, cond=00 -> W_En high exactly cycle 1, reg3=0x0008, N_q=Z_q=C_q=0, done in cycle 2.
2. reg1=0x0003; op=0111, srcS=1, dst=4, cnt=3 -> W_En high cycles 1-4, S_Addr=1 then 4,4,4, reg4=0x0030, done cycle 5.
3. op=0101, srcR=1, srcS=1, dst=5 -> reg5=0x0000, Z_q=1. Then op=0010, srcS=5, dst=6, cond=01 -> executes, reg6=0x0001. Then a cond=10 cmd -> W_En never asserted, done cycle 1, flags unchanged.
4. reg0=0x0000; op=0011, srcS=0, dst=7 -> reg7=0xFFFF, N_q=1, C_q=1, Z_q=0. Then a cond=11 cmd executes.
5. cmd_valid held high continuously with two commands -> second accepted only in IDLE after done. No command is lost or double-accepted; cmd_ready low throughout busy.
6. Start cnt=15 command, assert reset_n=0 during iteration 5 -> W_En=0 next cycle, all outputs at reset values, flags 0, cmd_ready=1 after reset released.
